// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin (or fixed) grant, word-aligned access,
// byte-enabled stores sequenced as read-modify-write, one response pulse per request.
module dmem_arbiter #(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned FIXED_PRIORITY = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             p0_valid,
   output logic             p0_ready,
   input  logic             p0_we,
   input  logic [WIDTH-1:0] p0_addr,
   input  logic [WIDTH-1:0] p0_wdata,
   input  logic [3:0]       p0_be,
   output logic             p0_resp,
   output logic [WIDTH-1:0] p0_rdata,
   input  logic             p1_valid,
   output logic             p1_ready,
   input  logic             p1_we,
   input  logic [WIDTH-1:0] p1_addr,
   input  logic [WIDTH-1:0] p1_wdata,
   input  logic [3:0]       p1_be,
   output logic             p1_resp,
   output logic [WIDTH-1:0] p1_rdata,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wd,
   input  logic [WIDTH-1:0] mem_rd
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR,
      RMW_RD,
      RMW_WR,
      RESP
   } state_t;

   state_t           state, state_nx;
   logic             last_grant;
   logic             port_q;
   logic [WIDTH-1:0] addr_q;
   logic [WIDTH-1:0] wdata_q;
   logic [3:0]       be_q;
   logic [WIDTH-1:0] merged_q;
   logic [WIDTH-1:0] rdata0_q;
   logic [WIDTH-1:0] rdata1_q;
   logic [WIDTH-1:0] mem_addr_q;

   logic             gnt_valid;
   logic             gnt_port;
   logic             accept;
   logic             sel_we;
   logic [WIDTH-1:0] sel_addr;
   logic [WIDTH-1:0] sel_aligned;
   logic [WIDTH-1:0] sel_wdata;
   logic [3:0]       sel_be;
   logic [WIDTH-1:0] mask;

   always_comb begin
      gnt_valid = p0_valid | p1_valid;
      if (p0_valid && p1_valid) begin
         gnt_port = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
      end else begin
         gnt_port = ~p0_valid;
      end
      accept      = (state == IDLE) && gnt_valid;
      sel_we      = gnt_port ? p1_we    : p0_we;
      sel_addr    = gnt_port ? p1_addr  : p0_addr;
      sel_wdata   = gnt_port ? p1_wdata : p0_wdata;
      sel_be      = gnt_port ? p1_be    : p0_be;
      sel_aligned = sel_addr & {{(WIDTH-2){1'b1}}, 2'b00};
   end

   always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         mask[8*i +: 8] = {8{be_q[i]}};
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!sel_we)                state_nx = RD;
               else if (sel_be == 4'hF)    state_nx = WR;
               else if (sel_be == 4'h0)    state_nx = RESP;
               else                        state_nx = RMW_RD;
            end
         end
         RD:      state_nx = RESP;
         WR:      state_nx = RESP;
         RMW_RD:  state_nx = RMW_WR;
         RMW_WR:  state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      p0_ready = accept & ~gnt_port;
      p1_ready = accept &  gnt_port;
      p0_resp  = (state == RESP) & ~port_q;
      p1_resp  = (state == RESP) &  port_q;
      mem_we   = (state == WR) || (state == RMW_WR);
      mem_wd   = (state == RMW_WR) ? merged_q : wdata_q;
      mem_addr = mem_addr_q;
      p0_rdata = rdata0_q;
      p1_rdata = rdata1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         port_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         merged_q   <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         mem_addr_q <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            port_q     <= gnt_port;
            last_grant <= gnt_port;
            addr_q     <= sel_aligned;
            wdata_q    <= sel_wdata;
            be_q       <= sel_be;
            // be=0 stores never reach memory, so the bus address is left as it was
            if (!(sel_we && (sel_be == 4'h0))) begin
               mem_addr_q <= sel_aligned;
            end
         end
         if (state == RD) begin
            if (port_q) rdata1_q <= mem_rd;
            else        rdata0_q <= mem_rd;
         end
         if (state == RMW_RD) begin
            merged_q <= (mem_rd & ~mask) | (wdata_q & mask);
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters, each with its own
// async-read/sync-write memory model, driven by the same requester stimulus.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_valid, p0_we, p1_valid, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [3:0]  p0_be, p1_be;

   logic        r_p0_ready, r_p1_ready, r_p0_resp, r_p1_resp, r_mem_we;
   logic [31:0] r_p0_rdata, r_p1_rdata, r_mem_addr, r_mem_wd, r_mem_rd;
   logic        f_p0_ready, f_p1_ready, f_p0_resp, f_p1_resp, f_mem_we;
   logic [31:0] f_p0_rdata, f_p1_rdata, f_mem_addr, f_mem_wd, f_mem_rd;

   logic [31:0] mem_r [0:63];
   logic [31:0] mem_f [0:63];
   logic        pre_en;
   logic [5:0]  pre_idx;
   logic [31:0] pre_val;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign r_mem_rd = mem_r[r_mem_addr[7:2]];
   assign f_mem_rd = mem_f[f_mem_addr[7:2]];

   always @(posedge clk) begin
      if (pre_en) begin
         mem_r[pre_idx] <= pre_val;
         mem_f[pre_idx] <= pre_val;
      end else begin
         if (r_mem_we) mem_r[r_mem_addr[7:2]] <= r_mem_wd;
         if (f_mem_we) mem_f[f_mem_addr[7:2]] <= f_mem_wd;
      end
   end

   dmem_arbiter #(.WIDTH(32), .FIXED_PRIORITY(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_valid(p0_valid), .p0_ready(r_p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_be(p0_be), .p0_resp(r_p0_resp), .p0_rdata(r_p0_rdata),
      .p1_valid(p1_valid), .p1_ready(r_p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_be(p1_be), .p1_resp(r_p1_resp), .p1_rdata(r_p1_rdata),
      .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wd(r_mem_wd), .mem_rd(r_mem_rd)
   );

   dmem_arbiter #(.WIDTH(32), .FIXED_PRIORITY(1)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .p0_valid(p0_valid), .p0_ready(f_p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_be(p0_be), .p0_resp(f_p0_resp), .p0_rdata(f_p0_rdata),
      .p1_valid(p1_valid), .p1_ready(f_p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_be(p1_be), .p1_resp(f_p1_resp), .p1_rdata(f_p1_rdata),
      .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wd(f_mem_wd), .mem_rd(f_mem_rd)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] val);
      pre_en  = 1'b1;
      pre_idx = idx;
      pre_val = val;
      tick();
      pre_en  = 1'b0;
   endtask

   // Presents one request, checks it is accepted alone, and returns one cycle after accept.
   task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      if (port == 1'b0) begin
         p0_valid = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_be = be;
      end else begin
         p1_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_be = be;
      end
      #1;
      chk("accept_ready", port ? r_p1_ready : r_p0_ready, 32'd1);
      chk("other_ready",  port ? r_p0_ready : r_p1_ready, 32'd0);
      tick();
      p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_be = '0;
      p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_be = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      pre_en = 1'b0; pre_idx = '0; pre_val = '0;
      p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_be = '0;
      p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_be = '0;
      #1;
      chk("rst_p0_ready", r_p0_ready, 32'd0);
      chk("rst_p1_ready", r_p1_ready, 32'd0);
      chk("rst_p0_resp",  r_p0_resp,  32'd0);
      chk("rst_p1_resp",  r_p1_resp,  32'd0);
      chk("rst_mem_we",   r_mem_we,   32'd0);
      chk("rst_p0_rdata", r_p0_rdata, 32'd0);
      chk("rst_p1_rdata", r_p1_rdata, 32'd0);
      chk("rst_mem_addr", r_mem_addr, 32'd0);
      tick();
      rst_n = 1'b1;
      preload(6'd4,  32'hDEADBEEF);
      preload(6'd12, 32'hAABBCCDD);

      // 1: p0 load from 0x10
      issue(1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
      chk("t1_rd_resp",    r_p0_resp,  32'd0);
      chk("t1_rd_addr",    r_mem_addr, 32'h10);
      chk("t1_rd_we",      r_mem_we,   32'd0);
      tick();
      chk("t1_resp",       r_p0_resp,  32'd1);
      chk("t1_rdata",      r_p0_rdata, 32'hDEADBEEF);
      chk("t1_p1_resp",    r_p1_resp,  32'd0);
      chk("t1_p1_rdata",   r_p1_rdata, 32'd0);
      tick();
      chk("t1_resp_end",   r_p0_resp,  32'd0);

      // 2: p1 full store then load
      issue(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
      chk("t2_wr_we",      r_mem_we,   32'd1);
      chk("t2_wr_addr",    r_mem_addr, 32'h20);
      chk("t2_wr_wd",      r_mem_wd,   32'h12345678);
      chk("t2_wr_resp",    r_p1_resp,  32'd0);
      tick();
      chk("t2_resp_we",    r_mem_we,   32'd0);
      chk("t2_resp",       r_p1_resp,  32'd1);
      chk("t2_mem",        mem_r[8],   32'h12345678);
      chk("t2_rdata_keep", r_p1_rdata, 32'd0);
      tick();
      issue(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
      tick();
      chk("t2_ld_resp",    r_p1_resp,  32'd1);
      chk("t2_ld_rdata",   r_p1_rdata, 32'h12345678);
      chk("t2_p0_keep",    r_p0_rdata, 32'hDEADBEEF);
      tick();

      // 3: p0 partial store be=0101 into 0xAABBCCDD
      issue(1'b0, 1'b1, 32'h30, 32'h11223344, 4'b0101);
      chk("t3_rmwrd_we",   r_mem_we,   32'd0);
      chk("t3_rmwrd_addr", r_mem_addr, 32'h30);
      tick();
      chk("t3_rmwwr_we",   r_mem_we,   32'd1);
      chk("t3_rmwwr_wd",   r_mem_wd,   32'hAA22CC44);
      chk("t3_rmwwr_resp", r_p0_resp,  32'd0);
      tick();
      chk("t3_resp",       r_p0_resp,  32'd1);
      chk("t3_mem",        mem_r[12],  32'hAA22CC44);
      chk("t3_rdata_keep", r_p0_rdata, 32'hDEADBEEF);
      tick();

      // 4: both ports loading continuously after reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h10; p0_be = 4'hF;
      p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h20; p1_be = 4'hF;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("t4_rr_p0_ready", r_p0_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("t4_rr_p1_ready", r_p1_ready, (i % 2 == 1) ? 32'd1 : 32'd0);
         chk("t4_fp_p0_ready", f_p0_ready, 32'd1);
         chk("t4_fp_p1_ready", f_p1_ready, 32'd0);
         tick();
         tick();
         if (i % 2 == 0) begin
            chk("t4_rr_p0_resp",  r_p0_resp,  32'd1);
            chk("t4_rr_p0_rdata", r_p0_rdata, 32'hDEADBEEF);
         end else begin
            chk("t4_rr_p1_resp",  r_p1_resp,  32'd1);
            chk("t4_rr_p1_rdata", r_p1_rdata, 32'h12345678);
         end
         chk("t4_fp_p0_resp",  f_p0_resp,  32'd1);
         chk("t4_fp_p1_resp",  f_p1_resp,  32'd0);
         tick();
      end
      chk("t4_fp_p1_rdata", f_p1_rdata, 32'd0);
      p0_valid = 1'b0; p1_valid = 1'b0;

      // 5: be=0 store, then misaligned load
      preload(6'd16, 32'h00000055);
      #1;
      chk("t5_idle_we", r_mem_we, 32'd0);
      issue(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0);
      chk("t5_resp",      r_p0_resp,  32'd1);
      chk("t5_we",        r_mem_we,   32'd0);
      chk("t5_addr_hold", r_mem_addr, 32'h20);
      tick();
      chk("t5_resp_end",  r_p0_resp,  32'd0);
      chk("t5_mem",       mem_r[16],  32'h00000055);
      issue(1'b1, 1'b0, 32'h13, 32'h0, 4'hF);
      chk("t5_mis_addr",  r_mem_addr, 32'h10);
      chk("t5_mis_we",    r_mem_we,   32'd0);
      tick();
      chk("t5_mis_resp",  r_p1_resp,  32'd1);
      chk("t5_mis_rdata", r_p1_rdata, 32'hDEADBEEF);
      tick();

      // 6: reset during RMW_WR
      issue(1'b0, 1'b1, 32'h30, 32'h00000000, 4'b0011);
      tick();
      chk("t6_rmwwr_we", r_mem_we, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_we",   r_mem_we,  32'd0);
      chk("t6_async_resp", r_p0_resp, 32'd0);
      tick();
      chk("t6_rst_resp",   r_p0_resp, 32'd0);
      chk("t6_mem",        mem_r[12], 32'hAA22CC44);
      rst_n = 1'b1;
      p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h30; p0_be = 4'hF;
      p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h20; p1_be = 4'hF;
      #1;
      chk("t6_tie_p0", r_p0_ready, 32'd1);
      chk("t6_tie_p1", r_p1_ready, 32'd0);
      tick();
      p0_valid = 1'b0; p1_valid = 1'b0;
      tick();
      chk("t6_ld_resp",  r_p0_resp,  32'd1);
      chk("t6_ld_rdata", r_p0_rdata, 32'hAA22CC44);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller in front of the word-addressed data memory (async read, sync write, byte addressing).
- Port 0 is the core load/store path; port 1 is the loader/debug path.
- Arbitrates between the ports with round-robin priority and sequences byte-enabled stores as read-modify-write.
- Returns one response pulse per accepted request.

Parameters:
- WIDTH, 32, data/address width; only 32 is supported because byte enables are 4 bits.
- FIXED_PRIORITY, 0, 0 selects round-robin; 1 makes port 0 always win.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_valid / p1_valid  in  1  request valid.
- p0_ready / p1_ready  out  1  request accepted this cycle.
- p0_we / p1_we  in  1  1 = store, 0 = load.
- p0_addr / p1_addr  in  WIDTH  byte address.
- p0_wdata / p1_wdata  in  WIDTH  store data.
- p0_be / p1_be  in  4  byte enables; bit i enables byte lane i.
- p0_resp / p1_resp  out  1  one-cycle completion pulse.
- p0_rdata / p1_rdata  out  WIDTH  load data, registered.
- mem_we  out  1  to memory write enable.
- mem_addr  out  WIDTH  to memory byte address; bits [1:0] are always 0.
- mem_wd  out  WIDTH  to memory write data.
- mem_rd  in  WIDTH  from memory, combinational read data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; last_grant=1, so port 0 wins the first tie.
  - All ready, resp and mem_we = 0; rdata regs = 0; latched request regs = 0.
- Any transaction in flight is dropped on reset: no response is issued, and mem_we falls immediately with no clock edge.
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE:
  - pX_ready = grant to X, combinational; both readies are 0 in all other states.
  - Grant rule: only one valid → that port. Both valid → port != last_grant, or port 0 if FIXED_PRIORITY=1.
  - On grant: latch port id, we, {addr[31:2],2'b00}, wdata and be; update last_grant.
  - Next state:
    - we=0 → RD
    - we=1 & be=4'hF → WR
    - we=1 & be=0 → RESP (no memory write)
    - otherwise → RMW_RD
- RD: drive mem_addr; capture mem_rd into that port's rdata reg at the edge; → RESP.
- WR: mem_we=1, mem_wd=wdata; → RESP.
- RMW_RD:
  - Drive mem_addr with mem_we=0.
  - Register merged = (mem_rd & ~mask) | (wdata & mask), where mask byte i = {8{be[i]}}.
  - → RMW_WR.
- RMW_WR: mem_we=1, mem_wd=merged; → RESP.
- RESP: granted port's resp=1 for exactly this cycle; → IDLE.
- Stores leave rdata regs unchanged. The non-granted port's rdata never changes.
- Latency, counted from the accept cycle T (ready=1):
  - load / full store: resp at T+2
  - partial store: resp at T+3
  - be=0 store: resp at T+1
  - The next accept is possible no earlier than the cycle after resp.
- Requester inputs are ignored after accept; changing them mid-transaction has no effect.
- A request that is not granted must be held by its requester; the arbiter keeps no memory of ungranted requests.
- mem_addr = latched address in RD/WR/RMW states and holds its last value otherwise. mem_we is 1 only in WR and RMW_WR.
- Address bits [1:0] are discarded; misaligned addresses access the containing word without error.
- No response backpressure: a response is delivered as a pulse and is never repeated.

Test Plan:
1. Reset, then p0 load addr 0x10 with mem word[4]=0xDEADBEEF.
   - p0_ready at T, p0_resp at T+2, p0_rdata=0xDEADBEEF.
   - p1 signals stay idle throughout.
2. p1 full store addr 0x20 data 0x12345678 be=F, then p1 load 0x20.
   - mem_we exactly one cycle at T+1.
   - The load returns 0x12345678.
3. Word 0x30 preloaded 0xAABBCCDD; p0 store data 0x11223344 be=4'b0101.
   - Memory becomes 0xAA22CC44.
   - mem_we=0 at T+1 and 1 at T+2; p0_resp at T+3.
4. Both ports valid every cycle with loads for 6 transactions after reset.
   - Grants alternate p0, p1, p0, p1, …
   - With FIXED_PRIORITY=1, all grants go to p0.
5. Store with be=0 and load with addr 0x13.
   - be=0 store: no mem_we pulse, resp at T+1.
   - addr 0x13 load: mem_addr=0x10 and the word at 0x10 is returned.
6. Assert rst_n low during RMW_WR.
   - mem_we drops to 0 asynchronously; no resp pulse.
   - Memory is unchanged.
   - After release, the first tie goes to p0.
